// File: rtl/avalon_pixel_reader.sv
// Avalon-MM read master that walks a frame in raster order (Y inner, X outer), one read in flight.
// Define BORDER_ZERO_EN to emit border pixels as 0 without issuing a memory read.
module avalon_pixel_reader #(
    parameter int                    X_END      = 3,
    parameter int                    Y_END      = 3,
    parameter int                    X_WIDTH    = 2,
    parameter int                    Y_WIDTH    = 2,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic [ADDR_WIDTH-1:0] avm_address_o,
    output logic                  avm_read_o,
    input  logic                  avm_waitrequest_i,
    input  logic [DATA_WIDTH-1:0] avm_readdata_i,
    input  logic                  avm_readdatavalid_i,
    output logic [DATA_WIDTH-1:0] pix_data_o,
    output logic [X_WIDTH-1:0]    pix_x_o,
    output logic [Y_WIDTH-1:0]    pix_y_o,
    output logic                  pix_valid_o,
    input  logic                  pix_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [2:0]            dbg_state_o
);

    // Pixel handshake: a pixel transfers on a clock edge where pix_valid_o and pix_ready_i are
    // both high. Once pix_valid_o rises it stays high, with data and coordinates frozen, until
    // that transfer happens; pix_valid_o never depends combinationally on pix_ready_i.

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_OUT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

`ifdef BORDER_ZERO_EN
    localparam bit LP_BORDER = 1'b1;
`else
    localparam bit LP_BORDER = 1'b0;
`endif

    localparam logic [X_WIDTH-1:0] LP_X_END = X_WIDTH'(X_END);
    localparam logic [Y_WIDTH-1:0] LP_Y_END = Y_WIDTH'(Y_END);

    state_t                r_state;
    logic [X_WIDTH-1:0]    r_x;
    logic [Y_WIDTH-1:0]    r_y;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_read;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_last_x;
    logic                  w_last_y;
    logic [X_WIDTH-1:0]    w_next_x;
    logic [Y_WIDTH-1:0]    w_next_y;
    logic                  w_next_border;

    assign w_last_x      = (r_x == LP_X_END);
    assign w_last_y      = (r_y == LP_Y_END);
    assign w_next_x      = w_last_y ? (r_x + X_WIDTH'(1)) : r_x;
    assign w_next_y      = w_last_y ? '0 : (r_y + Y_WIDTH'(1));
    assign w_next_border = (w_next_x == '0) || (w_next_x == LP_X_END) ||
                           (w_next_y == '0) || (w_next_y == LP_Y_END);

    // The word address tracks the raster index, so advancing one pixel is a plain increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_addr  <= BASE_ADDR;
            r_read  <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_x    <= '0;
                        r_y    <= '0;
                        r_addr <= BASE_ADDR;
                        r_busy <= 1'b1;
                        if (LP_BORDER) begin
                            r_state <= S_OUT;
                            r_data  <= '0;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= S_REQ;
                            r_read  <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (!avm_waitrequest_i) begin
                        r_read  <= 1'b0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (avm_readdatavalid_i) begin
                        r_data  <= avm_readdata_i;
                        r_valid <= 1'b1;
                        r_state <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (pix_ready_i) begin
                        r_valid <= 1'b0;
                        if (w_last_x && w_last_y) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_x    <= w_next_x;
                            r_y    <= w_next_y;
                            r_addr <= r_addr + ADDR_WIDTH'(1);
                            if (LP_BORDER && w_next_border) begin
                                r_state <= S_OUT;
                                r_data  <= '0;
                                r_valid <= 1'b1;
                            end else begin
                                r_state <= S_REQ;
                                r_read  <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_x     <= '0;
                    r_y     <= '0;
                    r_addr  <= BASE_ADDR;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_read  <= 1'b0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign avm_address_o = r_addr;
    assign avm_read_o    = r_read;
    assign pix_data_o    = r_data;
    assign pix_x_o       = r_x;
    assign pix_y_o       = r_y;
    assign pix_valid_o   = r_valid;
    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign dbg_state_o   = r_state;

endmodule
